// File: rtl/sum_prod_sched_if.sv
// Bundles the requester operand channels and the tagged result channel
// of the shared sum-plus-product scheduler.
interface sum_prod_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*WIDTH-1:0] req_c;
  logic                     res_valid;
  logic                     res_ready;
  logic [WIDTH-1:0]         res_a;
  logic [ID_W-1:0]          res_id;
  logic                     busy;

  modport master (
    output req_valid, req_b, req_c, res_ready,
    input  req_ready, res_valid, res_a, res_id, busy
  );

  modport slave (
    input  req_valid, req_b, req_c, res_ready,
    output req_ready, res_valid, res_a, res_id, busy
  );
endinterface

// File: rtl/sum_prod_sched.sv
// Round-robin scheduler feeding one sequential shift-add engine that
// computes a = (b + c) + (b * c) mod 2^WIDTH, returning results tagged by requester.
module sum_prod_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic            clk,
  input logic            rst,
  sum_prod_sched_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   c_r;
  logic [WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]   acc_s;
  logic [WIDTH-1:0]   res_a_r;
  logic [WIDTH-1:0]   sel_b_s;
  logic [WIDTH-1:0]   sel_c_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [ID_W-1:0]    id_r;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    res_id_r;
  logic [ID_W-1:0]    grant_id_s;
  logic [NUM_REQ-1:0] rot_s;
  logic [NUM_REQ-1:0] req_ready_s;
  int                 pos_s;
  logic               grant_found_s;
  logic               accept_s;
  logic               last_iter_s;
  logic               res_valid_r;
  logic               busy_r;

  // Rotate valids so bit 0 is rr_ptr; the lowest set bit wins (scan runs downward).
  always_comb begin
    grant_found_s = 1'b0;
    pos_s         = 0;
    grant_id_s    = {ID_W{1'b0}};
    rot_s         = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_r);
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        grant_found_s = 1'b1;
        pos_s         = int'(rr_ptr_r) + k;
      end else begin
        pos_s = pos_s;
      end
    end
    if (pos_s >= NUM_REQ) begin
      grant_id_s = ID_W'(pos_s - NUM_REQ);
    end else begin
      grant_id_s = ID_W'(pos_s);
    end
  end

  // One-hot ready to the winner, only while idle; operands of the winner.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    accept_s    = 1'b0;
    sel_b_s     = WIDTH'(bus.req_b >> (int'(grant_id_s) * WIDTH));
    sel_c_s     = WIDTH'(bus.req_c >> (int'(grant_id_s) * WIDTH));
    if ((state_r == IDLE) && grant_found_s) begin
      req_ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_s;
      accept_s    = 1'b1;
    end else begin
      req_ready_s = {NUM_REQ{1'b0}};
      accept_s    = 1'b0;
    end
  end

  // Next state plus the shift-add step of the current iteration.
  always_comb begin
    state_s     = state_r;
    last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
    acc_s       = acc_r + (c_r[0] ? b_r : {WIDTH{1'b0}});
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (last_iter_s) begin
          state_s = DONE;
        end else begin
          state_s = MUL;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, fixed-length multiply iterations and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_r         <= {WIDTH{1'b0}};
      c_r         <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      id_r        <= {ID_W{1'b0}};
      rr_ptr_r    <= {ID_W{1'b0}};
      res_a_r     <= {WIDTH{1'b0}};
      res_id_r    <= {ID_W{1'b0}};
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            b_r   <= sel_b_s;
            c_r   <= sel_c_s;
            acc_r <= sel_b_s + sel_c_s;
            id_r  <= grant_id_s;
            cnt_r <= {CNT_W{1'b0}};
            if (grant_id_s == ID_W'(NUM_REQ - 1)) begin
              rr_ptr_r <= {ID_W{1'b0}};
            end else begin
              rr_ptr_r <= grant_id_s + ID_W'(1);
            end
          end
        end
        MUL: begin
          acc_r <= acc_s;
          b_r   <= b_r << 1;
          c_r   <= c_r >> 1;
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_iter_s) begin
            res_valid_r <= 1'b1;
            res_a_r     <= acc_s;
            res_id_r    <= id_r;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
          end
        end
        default: res_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.res_valid = res_valid_r;
  assign bus.res_a     = res_a_r;
  assign bus.res_id    = res_id_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_sum_prod_sched.sv
// Directed scoreboard bench for sum_prod_sched: grant order, fixed latency,
// wrap-around arithmetic, back-pressure and mid-operation reset.
module tb_sum_prod_sched;
  localparam int NR = 4;
  localparam int W  = 32;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] a;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sum_prod_sched_if #(.NUM_REQ(NR), .WIDTH(W)) bus();
  sum_prod_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [31:0] b, input logic [31:0] c);
    bus.req_b     = (bus.req_b & ~(128'hFFFFFFFF << (id * 32))) | (128'(b) << (id * 32));
    bus.req_c     = (bus.req_c & ~(128'hFFFFFFFF << (id * 32))) | (128'(c) << (id * 32));
    bus.req_valid = bus.req_valid | (4'b0001 << id);
  endtask

  task automatic drive_req(input int id, input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] exp_a);
    exp_t e;
    set_req(id, b, c);
    e.id = 2'(id);
    e.a  = exp_a;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge (+1).
  task automatic await_grant(input int id, output int n);
    n = 0;
    #1;
    while (bus.req_ready == 4'b0000 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant_onehot", 64'(bus.req_ready), 64'(4'b0001 << id));
    @(negedge clk);
    bus.req_valid = bus.req_valid & ~(4'b0001 << id);
    #1;
    check("ready_low_in_mul", 64'(bus.req_ready), 64'd0);
    check("busy_in_mul", 64'(bus.busy), 64'd1);
  endtask

  task automatic await_result(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_id"}, 64'(bus.res_id), 64'(e.id));
      check({tag, "_a"}, 64'(bus.res_a), 64'(e.a));
    end
  endtask

  initial begin
    int   n;
    logic seen;
    rst           = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_b     = 128'd0;
    bus.req_c     = 128'd0;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_a", 64'(bus.res_a), 64'd0);
    check("rst_res_id", 64'(bus.res_id), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);

    // Basic single request, granted on the first idle cycle.
    drive_req(1, 32'd3, 32'd4, 32'd19);
    await_grant(1, n);
    check("basic_first_cycle", 64'(n), 64'd0);
    await_result("basic");
    @(negedge clk);
    check("basic_idle_after_hs", 64'(bus.busy), 64'd0);

    // Signed and wrap-around products.
    drive_req(2, 32'hFFFFFFFE, 32'd5, 32'hFFFFFFF9);
    await_grant(2, n);
    await_result("signed");
    @(negedge clk);
    drive_req(0, 32'h00010000, 32'h00010000, 32'h00020000);
    await_grant(0, n);
    await_result("wrap");
    @(negedge clk);

    // Edge operands.
    drive_req(3, 32'h7FFFFFFF, 32'd1, 32'hFFFFFFFF);
    await_grant(3, n);
    await_result("maxpos");
    @(negedge clk);
    drive_req(1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    await_grant(1, n);
    await_result("zero_b");
    @(negedge clk);

    // Round robin from reset with all requesters pending.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_req(0, 32'd1, 32'd2, 32'd5);
    drive_req(1, 32'd3, 32'd3, 32'd15);
    drive_req(2, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFF5);
    drive_req(3, 32'd100, 32'd100, 32'd10200);
    for (int k = 0; k < NR; k++) begin
      await_grant(k, n);
      await_result("rr_all");
      @(negedge clk);
    end
    drive_req(0, 32'd6, 32'd7, 32'd55);
    drive_req(2, 32'h12345678, 32'd0, 32'h12345678);
    await_grant(0, n);
    await_result("rr_pair");
    @(negedge clk);
    await_grant(2, n);
    await_result("rr_pair");
    @(negedge clk);

    // Back-pressure with another requester waiting.
    bus.res_ready = 1'b0;
    drive_req(1, 32'd10, 32'd20, 32'd230);
    await_grant(1, n);
    drive_req(3, 32'd2, 32'd3, 32'd11);
    await_result("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 64'(bus.res_valid), 64'd1);
      check("bp_a_hold", 64'(bus.res_a), 64'd230);
      check("bp_id_hold", 64'(bus.res_id), 64'd1);
      check("bp_ready_low", 64'(bus.req_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_valid", 64'(bus.res_valid), 64'd0);
    check("bp_release_busy", 64'(bus.busy), 64'd0);
    check("bp_release_grant", 64'(bus.req_ready), 64'(4'b1000));
    await_grant(3, n);
    await_result("bp_next");
    @(negedge clk);

    // Reset in the middle of a multiply discards the in-flight request.
    set_req(2, 32'd5, 32'd6);
    await_grant(2, n);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_res_valid", 64'(bus.res_valid), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_res_a", 64'(bus.res_a), 64'd0);
    check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    check("midrst_no_stale", 64'(seen), 64'd0);
    drive_req(1, 32'd0, 32'd0, 32'd0);
    drive_req(3, 32'd7, 32'd9, 32'd79);
    await_grant(1, n);
    await_result("post_rst");
    @(negedge clk);
    await_grant(3, n);
    await_result("post_rst");
    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
